// File: rtl/acmv_pcnt.sv
// Up/down counter with a priority-encoded step size, synchronous load and terminal-count pulses.
// Define ACMV_PCNT_SAT_EN to clamp at 0 / 2^W-1 instead of wrapping.
module acmv_pcnt #(
   parameter  int W    = 4,
   parameter  int OPTW = 4,
   localparam int PW   = $clog2(OPTW)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            a,
   input  logic            b,
   input  logic [OPTW-1:0] opt,
   input  logic            ld,
   input  logic [W-1:0]    ld_val,
   output logic [W-1:0]    x,
   output logic [PW-1:0]   pri,
   output logic            pri_vld,
   output logic            tc_up,
   output logic            tc_dn
);

   // Two guard bits hold a step of up to 2^W and the overflow/underflow comparisons.
   localparam int             SW    = W + 2;
   localparam logic [SW-1:0] MAX_X = SW'((1 << W) - 1);

   logic [W-1:0]  x_q, x_d;
   logic [PW-1:0] pri_q, pri_d;
   logic          pri_vld_q, pri_vld_d;
   logic          tc_up_q, tc_up_d;
   logic          tc_dn_q, tc_dn_d;

   logic [SW-1:0] step;
   logic [SW-1:0] x_ext;
   logic [W-1:0]  sum;
   logic [W-1:0]  diff;
   logic          up_ovf;
   logic          dn_unf;

   // Ascending scan: the last set bit seen is the highest, so lower bits are ignored.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      pri_d     = pri_q;
      pri_vld_d = 1'b0;
      for (int i = 0; i < OPTW; i++) begin
         if (opt[i]) begin
            pri_d     = PW'(i);
            pri_vld_d = 1'b1;
         end
      end
   end

   // The step comes from the registered encoder, so an opt change takes effect one cycle later.
   assign step   = pri_vld_q ? (SW'(pri_q) + SW'(1)) : SW'(1);
   assign x_ext  = SW'(x_q);
   assign sum    = x_q + step[W-1:0];
   assign diff   = x_q - step[W-1:0];
   assign up_ovf = (step > (MAX_X - x_ext));
   assign dn_unf = (step > x_ext);

   always_comb begin
      x_d     = x_q;
      tc_up_d = 1'b0;
      tc_dn_d = 1'b0;
      if (ld) begin
         x_d = ld_val;
      end else if (en) begin
         if (a == b) begin
            tc_up_d = up_ovf;
`ifdef ACMV_PCNT_SAT_EN
            x_d     = up_ovf ? MAX_X[W-1:0] : sum;
`else
            x_d     = sum;
`endif
         end else begin
            tc_dn_d = dn_unf;
`ifdef ACMV_PCNT_SAT_EN
            x_d     = dn_unf ? '0 : diff;
`else
            x_d     = diff;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         x_q       <= '0;
         pri_q     <= '0;
         pri_vld_q <= 1'b0;
         tc_up_q   <= 1'b0;
         tc_dn_q   <= 1'b0;
      end else begin
         x_q       <= x_d;
         pri_q     <= pri_d;
         pri_vld_q <= pri_vld_d;
         tc_up_q   <= tc_up_d;
         tc_dn_q   <= tc_dn_d;
      end
   end

   assign x       = x_q;
   assign pri     = pri_q;
   assign pri_vld = pri_vld_q;
   assign tc_up   = tc_up_q;
   assign tc_dn   = tc_dn_q;

endmodule

// File: tb/tb_acmv_pcnt.sv
// Self-checking bench for acmv_pcnt (W=4, OPTW=4): vector table, corner sequences, random vs model.
// Honors ACMV_PCNT_SAT_EN for build-dependent expectations.
module tb_acmv_pcnt;

   logic       clk = 1'b0;
   logic       rst, en, a, b, ld;
   logic [3:0] opt, ld_val;
   logic [3:0] x;
   logic [1:0] pri;
   logic       pri_vld, tc_up, tc_dn;

   int checks = 0;
   int errors = 0;

   // Reference state: plain integers, counter value kept in 0..15.
   int m_x = 0, m_pri = 0, m_vld = 0, m_up = 0, m_dn = 0;

   typedef struct {
      logic       rst, en, a, b;
      logic [3:0] opt;
      logic       ld;
      logic [3:0] ld_val;
      int         ex, ep, ev, eu, ed;
   } vec_t;

   vec_t tbl[14];

   always #5 clk = ~clk;

   acmv_pcnt #(.W(4), .OPTW(4)) dut (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .opt(opt), .ld(ld), .ld_val(ld_val),
      .x(x), .pri(pri), .pri_vld(pri_vld), .tc_up(tc_up), .tc_dn(tc_dn)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_step();
      int step, t, hp;
      if (rst) begin
         m_x = 0; m_pri = 0; m_vld = 0; m_up = 0; m_dn = 0;
         return;
      end
      step = (m_vld != 0) ? m_pri + 1 : 1;
      hp = -1;
      for (int i = 0; i < 4; i++) if (opt[i]) hp = i;
      if (hp >= 0) begin m_pri = hp; m_vld = 1; end
      else m_vld = 0;
      m_up = 0; m_dn = 0;
      if (ld) begin
         m_x = int'(ld_val);
      end else if (en) begin
         if (a == b) begin
            t = m_x + step;
            if (t > 15) begin
               m_up = 1;
`ifdef ACMV_PCNT_SAT_EN
               t = 15;
`else
               t = t - 16;
`endif
            end
         end else begin
            t = m_x - step;
            if (t < 0) begin
               m_dn = 1;
`ifdef ACMV_PCNT_SAT_EN
               t = 0;
`else
               t = t + 16;
`endif
            end
         end
         m_x = t;
      end
   endtask

   task automatic cyc(input logic r, input logic e, input logic aa, input logic bb,
                      input logic [3:0] o, input logic l, input logic [3:0] lv);
      rst = r; en = e; a = aa; b = bb; opt = o; ld = l; ld_val = lv;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input int ex, input int ep, input int ev,
                             input int eu, input int ed);
      check($sformatf("%s.x", tag), int'(x), ex);
      check($sformatf("%s.pri", tag), int'(pri), ep);
      check($sformatf("%s.pri_vld", tag), int'(pri_vld), ev);
      check($sformatf("%s.tc_up", tag), int'(tc_up), eu);
      check($sformatf("%s.tc_dn", tag), int'(tc_dn), ed);
   endtask

   initial begin
      // rst en a b opt ld ld_val | x pri vld up dn  (no boundary crossings, so build-independent)
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0, 0, 0, 0, 0, 0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0, 1, 0, 0, 0, 0};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0, 2, 0, 0, 0, 0};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b1010, 1'b0, 4'd0, 3, 3, 1, 0, 0};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0, 7, 3, 0, 0, 0};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0, 8, 3, 0, 0, 0};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, 1'b1, 4'd9, 9, 1, 1, 0, 0};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0, 9, 1, 0, 0, 0};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'd0, 8, 1, 0, 0, 0};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b0, 4'd0, 7, 3, 1, 0, 0};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b1000, 1'b0, 4'd0, 3, 3, 1, 0, 0};
      tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b0, 4'd0, 7, 0, 1, 0, 0};
      tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 4'd0, 8, 2, 1, 0, 0};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 4'd0, 5, 2, 0, 0, 0};

      rst = 1'b0; en = 1'b0; a = 1'b0; b = 1'b0; opt = '0; ld = 1'b0; ld_val = '0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 14; i++) begin
         cyc(tbl[i].rst, tbl[i].en, tbl[i].a, tbl[i].b, tbl[i].opt, tbl[i].ld, tbl[i].ld_val);
         expect_out($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ep, tbl[i].ev, tbl[i].eu, tbl[i].ed);
      end

      // Full up-count sweep with step 1.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0);
      expect_out("sweep_rst", 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0);
         if (i < 15) expect_out($sformatf("sweep%0d", i), i + 1, 0, 0, 0, 0);
`ifdef ACMV_PCNT_SAT_EN
         else expect_out("sweep_end", 15, 0, 0, 1, 0);
`else
         else expect_out("sweep_end", 0, 0, 0, 1, 0);
`endif
      end

      // Step 4 from opt=1010, applied one cycle after opt is sampled.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 1'b0, 4'd0);
      expect_out("step4_pri", 0, 3, 1, 0, 0);
      for (int i = 1; i <= 3; i++) begin
         cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b1010, 1'b0, 4'd0);
         expect_out($sformatf("step4_%0d", i), 4 * i, 3, 1, 0, 0);
      end
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b1010, 1'b0, 4'd0);
`ifdef ACMV_PCNT_SAT_EN
      expect_out("step4_wrap", 15, 3, 1, 1, 0);
`else
      expect_out("step4_wrap", 0, 3, 1, 1, 0);
`endif

      // Down-count through zero.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 4'd0);
`ifdef ACMV_PCNT_SAT_EN
      expect_out("down_wrap", 0, 0, 0, 0, 1);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 4'd0);
      expect_out("down_next", 0, 0, 0, 0, 1);
`else
      expect_out("down_wrap", 15, 0, 0, 0, 1);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 4'd0);
      expect_out("down_next", 14, 0, 0, 0, 0);
`endif

      // Load takes precedence over counting, then hold.
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'd3);
      expect_out("ld3", 3, 0, 0, 0, 0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 4'd9);
      expect_out("ld9", 9, 0, 0, 0, 0);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 4'd0);
      expect_out("hold1", 9, 0, 0, 0, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'd0);
      expect_out("hold2", 9, 0, 0, 0, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'd15);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 4'd15);
      expect_out("ld_at_max", 15, 0, 0, 0, 0);

      // Reset overrides load, enable and a pending step.
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 4'd7);
      expect_out("pre_rst", 7, 2, 1, 0, 0);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, 4'd9);
      expect_out("mid_rst", 0, 0, 0, 0, 0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 4'd0);
      expect_out("post_rst", 1, 0, 0, 0, 0);

      // Step 4 from 14: clamp (and repeated clamp) or wrap.
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 4'd14);
      expect_out("near_max", 14, 3, 1, 0, 0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b0, 4'd0);
`ifdef ACMV_PCNT_SAT_EN
      expect_out("clamp1", 15, 3, 1, 1, 0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b0, 4'd0);
      expect_out("clamp2", 15, 3, 1, 1, 0);
`else
      expect_out("cross1", 2, 3, 1, 1, 0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b0, 4'd0);
      expect_out("cross2", 6, 3, 1, 0, 0);
`endif

      // Random traffic against the reference model.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0);
      for (int n = 0; n < 1500; n++) begin
         cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
             1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom),
             ($urandom_range(0, 9) == 0), 4'($urandom));
         expect_out($sformatf("rnd%0d", n), m_x, m_pri, m_vld, m_up, m_dn);
         check($sformatf("rnd%0d.tc_excl", n), int'(tc_up & tc_dn), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/acmv_pcnt.md
ACMV_PCNT -- requirements
Module: acmv_pcnt

Interface
REQ-001 SHALL have parameter W, default 4: counter width, legal range 2..16.
REQ-002 SHALL have parameter OPTW, default 4: option vector width, legal range 2..2^W; PW = $clog2(OPTW).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have ports a, b  input  1 each  direction compare pair: a==b counts up, a!=b counts down.
REQ-007 SHALL have port opt  input  OPTW  priority-encoded step-select vector.
REQ-008 SHALL have port ld  input  1  synchronous load strobe.
REQ-009 SHALL have port ld_val  input  W  load value.
REQ-010 SHALL have port x  output  W  counter value (registered).
REQ-011 SHALL have port pri  output  PW  registered index of the highest set bit of opt.
REQ-012 SHALL have port pri_vld  output  1  registered; 1 when opt had any bit set.
REQ-013 SHALL have ports tc_up, tc_dn  output  1 each  one-cycle terminal-count pulses.

Function
REQ-014 SHALL, every cycle regardless of en, register pri = index of the highest set bit of opt and pri_vld = |opt.
REQ-015 SHALL, when opt==0, hold pri at its previous value and clear pri_vld.
REQ-016 SHALL use step = pri+1 when pri_vld=1, else step = 1, taken from the registered pri/pri_vld; an opt change affects the count one cycle later.
REQ-017 SHALL give precedence rst > ld > en; ld loads x = ld_val whether or not en is high, with no count and no tc pulse that cycle.
REQ-018 SHALL, with en=1 and ld=0, update x = x+step when a==b and x = x-step when a!=b, in W-bit arithmetic.
REQ-019 SHALL hold x unchanged when en=0 and ld=0, with tc_up=tc_dn=0.
REQ-020 SHALL, without saturation, wrap modulo 2^W and pulse tc_up for exactly one cycle (concurrent with the new x) when an up-count crosses 2^W-1 to a lower value.
REQ-021 SHALL likewise pulse tc_dn when a down-count crosses 0 to a higher value.
REQ-022 SHALL never assert tc_up and tc_dn in the same cycle.
REQ-023 SHALL accept any opt pattern, including multiple set bits; the lower set bits are ignored.

Reset
REQ-024 SHALL, in the cycle after rst=1 is sampled, drive x=0, pri=0, pri_vld=0, tc_up=0 and tc_dn=0.
REQ-025 SHALL let rst override ld, en and an in-flight step with no residual effect; counting resumes from 0 with step 1 on the first cycle after rst deasserts.

Configuration
REQ-026 SHALL support macro ACMV_PCNT_SAT_EN, which enables saturating arithmetic.
REQ-027 SHALL, with ACMV_PCNT_SAT_EN defined, clamp up-counts at 2^W-1 and down-counts at 0, and pulse tc_up/tc_dn for one cycle on each cycle a clamp occurs, including repeated attempts while already at the limit.
REQ-028 SHALL, with ACMV_PCNT_SAT_EN undefined, wrap as in REQ-020 and REQ-021; all other behaviour is identical in both builds.

Verification (W=4, OPTW=4)
REQ-029 SHALL cover: rst, then en=1, a=b, opt=0 for 16 cycles -> x steps 1..15 then 0, with a single tc_up pulse on the 0 cycle.
REQ-030 SHALL cover: opt=4'b1010 from x=0, a=b, en=1 -> pri=3 and pri_vld=1 one cycle later, then x advances by 4 per cycle (4, 8, 12, 0 with tc_up).
REQ-031 SHALL cover: x=0, a!=b, opt=0, en=1 -> x=15 with one tc_dn pulse, then 14.
REQ-032 SHALL cover: ld=1, en=1, ld_val=9, x=3 -> x=9 next cycle, no tc pulse; with ld=0, en=0 -> x holds at 9.
REQ-033 SHALL cover: rst=1 mid-count at x=7, opt=4'b0100 -> next cycle x=0, pri=0, pri_vld=0, tc=0.
REQ-034 SHALL cover: ACMV_PCNT_SAT_EN defined, x=14, pri=3 (step 4), a=b -> x=15 and tc_up=1; a second cycle -> x stays 15 and tc_up=1 again.
